// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer: arbitrates exception, interrupt and MRET
// requests, then walks the CSR write port through a fixed save sequence and redirects the PC.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            trap_ack_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_EPC, S_SAVE_CAUSE, S_SAVE_TVAL,
    S_UPD_STATUS, S_MRET_STATUS, S_REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, tval_q, tval_d;
  logic            is_irq_q, is_irq_d, is_mret_q, is_mret_d;

  // irq_i is {MEI, MTI, MSI}; service order is MEI, then MSI, then MTI.
  logic [2:0] irq_en;
  logic       irq_take;
  logic [3:0] irq_code;
  logic [XLEN-1:0] vec_base;

  assign irq_en   = irq_i & {mie_i[11], mie_i[7], mie_i[3]} & {3{mstatus_i[3]}};
  assign irq_take = |irq_en;
  assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};
  assign dbg_state_o = state_q;

  always_comb begin
    irq_code = 4'd0;
    if (irq_en[2])      irq_code = 4'd11;
    else if (irq_en[0]) irq_code = 4'd3;
    else if (irq_en[1]) irq_code = 4'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      is_irq_q  <= is_irq_d;
      is_mret_q <= is_mret_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    is_irq_d         = is_irq_q;
    is_mret_d        = is_mret_q;
    csr_we_o         = 1'b0;
    csr_addr_o       = 12'h000;
    csr_wdata_o      = '0;
    stall_o          = 1'b0;
    trap_ack_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;

    // Outputs are held quiet while reset is asserted so nothing escapes a mid-sequence reset.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (exc_req_i) begin
            trap_ack_o = 1'b1;
            pc_d       = pc_i;
            cause_d    = exc_cause_i;
            tval_d     = exc_tval_i;
            is_irq_d   = 1'b0;
            is_mret_d  = 1'b0;
            state_d    = S_SAVE_EPC;
          end else if (irq_take) begin
            trap_ack_o = 1'b1;
            pc_d       = pc_i;
            cause_d    = {1'b1, {(XLEN-5){1'b0}}, irq_code};
            tval_d     = '0;
            is_irq_d   = 1'b1;
            is_mret_d  = 1'b0;
            state_d    = S_SAVE_EPC;
          end else if (mret_i) begin
            trap_ack_o = 1'b1;
            is_irq_d   = 1'b0;
            is_mret_d  = 1'b1;
            state_d    = S_MRET_STATUS;
          end
        end
        S_SAVE_EPC: begin
          stall_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_addr_o  = 12'h341;
          csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
          state_d     = S_SAVE_CAUSE;
        end
        S_SAVE_CAUSE: begin
          stall_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_addr_o  = 12'h342;
          csr_wdata_o = cause_q;
          state_d     = S_SAVE_TVAL;
        end
        S_SAVE_TVAL: begin
          stall_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_addr_o  = 12'h343;
          csr_wdata_o = tval_q;
          state_d     = S_UPD_STATUS;
        end
        S_UPD_STATUS: begin
          stall_o            = 1'b1;
          csr_we_o           = 1'b1;
          csr_addr_o         = 12'h300;
          csr_wdata_o        = mstatus_i;
          csr_wdata_o[7]     = mstatus_i[3];
          csr_wdata_o[3]     = 1'b0;
          csr_wdata_o[12:11] = 2'b11;
          state_d            = S_REDIRECT;
        end
        S_MRET_STATUS: begin
          stall_o            = 1'b1;
          csr_we_o           = 1'b1;
          csr_addr_o         = 12'h300;
          csr_wdata_o        = mstatus_i;
          csr_wdata_o[3]     = mstatus_i[7];
          csr_wdata_o[7]     = 1'b1;
          csr_wdata_o[12:11] = 2'b11;
          state_d            = S_REDIRECT;
        end
        S_REDIRECT: begin
          stall_o          = 1'b1;
          redirect_valid_o = 1'b1;
          if (is_mret_q)
            redirect_pc_o = {mepc_i[XLEN-1:2], 2'b00};
          else if (is_irq_q && mtvec_i[1:0] == 2'b01)
            redirect_pc_o = vec_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
          else
            redirect_pc_o = vec_base;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
